// File: rtl/touch_scan_scheduler_pkg.sv
// Shared definitions for the touchpad scan scheduler: channel codes, axis
// offsets, FSM states and the optional smoothing helper.
package touch_scan_scheduler_pkg;

  localparam logic [1:0] TOUCH_READ_X       = 2'b00;
  localparam logic [1:0] TOUCH_READ_Y       = 2'b01;
  localparam logic [1:0] TOUCH_READ_Z       = 2'b10;
  localparam logic [1:0] TOUCH_READ_INVALID = 2'b11;

  localparam logic [11:0] X_ADJ_MIN = 12'h090;
  localparam logic [11:0] Y_ADJ_MIN = 12'h060;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_REQ,
    ST_WAIT_DONE,
    ST_ACCUM,
    ST_PUBLISH
  } state_t;

  // Rounded mean of two 9-bit coordinates.
  function automatic logic [8:0] coord_avg2(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {1'b0, a} + {1'b0, b} + 10'd1;
    return s[9:1];
  endfunction

endpackage

// File: rtl/touch_scan_scheduler_axis_scale.sv
// Combinational average / offset / saturate from an accumulated raw sum to a
// 9-bit screen coordinate.
module touch_axis_scale
  import touch_scan_scheduler_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2,
  parameter logic [11:0] MIN      = 12'h000
) (
  input  logic [11+AVG_LOG2:0] i_sum,
  output logic [8:0]           o_coord
);

  logic [11:0] w_avg;
  logic [11:0] w_adj;
  logic [9:0]  w_q;

  always_comb begin
    w_avg   = 12'(i_sum >> AVG_LOG2);
    w_adj   = (w_avg < MIN) ? '0 : (w_avg - MIN);
    w_q     = 10'(w_adj >> 2);
    o_coord = (w_q > 10'd511) ? '1 : w_q[8:0];
  end

endmodule

// File: rtl/touch_scan_scheduler.sv
// Periodic Z/X/Y scan sequencer for the touchpad SPI engine.
// Optional build macro: TOUCH_SCHED_FILTER_EN (x/y smoothing across pen-down publishes).
module touch_scan_scheduler
  import touch_scan_scheduler_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 1_250_000,
  parameter int unsigned AVG_LOG2   = 2,
  parameter logic [11:0] Z_THRESH   = 12'h100,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        enable,
  output logic        xfer_req,
  output logic [1:0]  xfer_chan,
  input  logic        xfer_ack,
  input  logic        xfer_done,
  input  logic [11:0] xfer_data,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic [8:0]  z,
  output logic        pen_down,
  output logic        sample_valid,
  output logic        timeout_err
);

  localparam int unsigned SW = 12 + AVG_LOG2;
  localparam int unsigned DW = $clog2(SAMPLE_DIV);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [4:0]    RD_LAST  = 5'((1 << AVG_LOG2) - 1);

  state_t        r_state, w_next;
  logic [DW-1:0] r_div;
  logic          r_pending;
  logic [1:0]    r_chan;
  logic [4:0]    r_cnt;
  logic [SW-1:0] r_sum, r_xsum, r_ysum;
  logic [11:0]   r_data;
  logic [8:0]    r_zq;
  logic          r_scan_pen;
  logic [TW-1:0] r_to;
  logic [8:0]    r_x, r_y, r_z;
  logic          r_pen, r_valid, r_terr;

  logic          w_to_hit, w_rd_last, w_z_low;
  logic [SW-1:0] w_sum_next;
  logic [8:0]    w_x_new, w_y_new, w_x_pub, w_y_pub;

  assign w_to_hit   = (r_to == TO_LAST);
  assign w_rd_last  = (r_cnt == RD_LAST);
  assign w_z_low    = (r_data < Z_THRESH);
  assign w_sum_next = r_sum + SW'(r_data);

  touch_axis_scale #(.AVG_LOG2(AVG_LOG2), .MIN(X_ADJ_MIN)) u_scale_x (
    .i_sum   (r_xsum),
    .o_coord (w_x_new)
  );

  touch_axis_scale #(.AVG_LOG2(AVG_LOG2), .MIN(Y_ADJ_MIN)) u_scale_y (
    .i_sum   (r_ysum),
    .o_coord (w_y_new)
  );

`ifdef TOUCH_SCHED_FILTER_EN
  assign w_x_pub = r_pen ? coord_avg2(r_x, w_x_new) : w_x_new;
  assign w_y_pub = r_pen ? coord_avg2(r_y, w_y_new) : w_y_new;
`else
  assign w_x_pub = w_x_new;
  assign w_y_pub = w_y_new;
`endif

  always_ff @(posedge cclk) begin
    if (!rstb) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (enable) w_next = ST_WAIT_TICK;
      ST_WAIT_TICK: begin
        if (!enable)       w_next = ST_IDLE;
        else if (r_pending) w_next = ST_REQ;
      end
      ST_REQ:       if (xfer_ack) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (xfer_done)     w_next = ST_ACCUM;
        else if (w_to_hit) w_next = enable ? ST_WAIT_TICK : ST_IDLE;
      end
      ST_ACCUM: begin
        if (!enable)                                  w_next = ST_IDLE;
        else if (r_chan == TOUCH_READ_Z)              w_next = w_z_low ? ST_PUBLISH : ST_REQ;
        else if (r_chan == TOUCH_READ_Y && w_rd_last) w_next = ST_PUBLISH;
        else                                          w_next = ST_REQ;
      end
      ST_PUBLISH:   w_next = enable ? ST_WAIT_TICK : ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    xfer_req  = (r_state == ST_REQ);
    xfer_chan = (r_state == ST_REQ) ? r_chan : TOUCH_READ_INVALID;
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      r_div      <= '0;
      r_pending  <= 1'b0;
      r_chan     <= TOUCH_READ_Z;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_xsum     <= '0;
      r_ysum     <= '0;
      r_data     <= '0;
      r_zq       <= '0;
      r_scan_pen <= 1'b0;
      r_to       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_pen      <= 1'b0;
      r_valid    <= 1'b0;
      r_terr     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (enable) begin
        if (r_div == DIV_LAST) begin
          r_div     <= '0;
          r_pending <= 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
      // Consuming a tick or abandoning a scan both clear pending; placed after the set so it wins.
      if ((r_state == ST_WAIT_TICK && w_next == ST_REQ) ||
          (r_state != ST_IDLE && w_next == ST_IDLE))
        r_pending <= 1'b0;

      case (r_state)
        ST_WAIT_TICK: r_chan <= TOUCH_READ_Z;
        ST_REQ:       r_to   <= '0;
        ST_WAIT_DONE: begin
          r_to <= r_to + 1'b1;
          if (xfer_done)     r_data <= xfer_data;
          else if (w_to_hit) r_terr <= 1'b1;
        end
        ST_ACCUM: if (enable) begin
          if (r_chan == TOUCH_READ_Z) begin
            r_zq       <= r_data[11:3];
            r_scan_pen <= !w_z_low;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_chan     <= TOUCH_READ_X;
          end else if (w_rd_last) begin
            r_sum <= '0;
            r_cnt <= '0;
            if (r_chan == TOUCH_READ_X) begin
              r_xsum <= w_sum_next;
              r_chan <= TOUCH_READ_Y;
            end else begin
              r_ysum <= w_sum_next;
            end
          end else begin
            r_sum <= w_sum_next;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PUBLISH: begin
          r_valid <= 1'b1;
          r_z     <= r_zq;
          r_pen   <= r_scan_pen;
          if (r_scan_pen) begin
            r_x <= w_x_pub;
            r_y <= w_y_pub;
          end
        end
        default: ;
      endcase
    end
  end

  assign x            = r_x;
  assign y            = r_y;
  assign z            = r_z;
  assign pen_down     = r_pen;
  assign sample_valid = r_valid;
  assign timeout_err  = r_terr;

endmodule

// File: tb/tb_touch_scan_scheduler.sv
// Scoreboard bench for touch_scan_scheduler: stimulus tasks act as the SPI
// engine and queue expected publishes; a monitor checks every strobe.
module tb_touch_scan_scheduler;

  logic        cclk = 1'b0;
  logic        rstb = 1'b0;
  logic        enable = 1'b0;
  logic        xfer_ack = 1'b0;
  logic        xfer_done = 1'b0;
  logic [11:0] xfer_data = '0;
  logic        xfer_req;
  logic [1:0]  xfer_chan;
  logic [8:0]  x, y, z;
  logic        pen_down, sample_valid, timeout_err;

  always #5 cclk = ~cclk;

  touch_scan_scheduler #(
    .SAMPLE_DIV (200),
    .AVG_LOG2   (2),
    .Z_THRESH   (12'h100),
    .TIMEOUT    (4096)
  ) dut (
    .cclk         (cclk),
    .rstb         (rstb),
    .enable       (enable),
    .xfer_req     (xfer_req),
    .xfer_chan    (xfer_chan),
    .xfer_ack     (xfer_ack),
    .xfer_done    (xfer_done),
    .xfer_data    (xfer_data),
    .x            (x),
    .y            (y),
    .z            (z),
    .pen_down     (pen_down),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err)
  );

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [8:0] z;
    logic       pen;
  } pub_t;

  pub_t       exp_q[$];
  int         CHECKS = 0;
  int         ERRORS = 0;
  logic [8:0] m_x = '0;
  logic [8:0] m_y = '0;
  logic       m_pen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    CHECKS++;
    if (act !== req) begin
      ERRORS++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge cclk);
    #1;
  endtask

  // Engine model: wait for a request, hold it a cycle, ack (with a spurious
  // done/data in the same cycle), then optionally return a result.
  task automatic serve(input logic [1:0] ch, input logic [11:0] d, input bit do_done);
    int w = 0;
    while (!xfer_req && w < 1000) begin
      cyc(1);
      w++;
    end
    chk("req_seen", 32'(xfer_req), 32'd1);
    if (!xfer_req) return;
    chk("chan", 32'(xfer_chan), 32'(ch));
    cyc(1);
    chk("chan_hold", 32'({xfer_req, xfer_chan}), 32'({1'b1, ch}));
    xfer_ack  = 1'b1;
    xfer_done = 1'b1;
    xfer_data = 12'hABC;
    cyc(1);
    xfer_ack  = 1'b0;
    xfer_done = 1'b0;
    xfer_data = '0;
    chk("req_drop", 32'(xfer_req), 32'd0);
    if (!do_done) return;
    cyc(2);
    xfer_data = d;
    xfer_done = 1'b1;
    cyc(1);
    xfer_done = 1'b0;
    xfer_data = '0;
  endtask

  task automatic scan_up(input logic [11:0] zr);
    pub_t e;
    e.x = m_x; e.y = m_y; e.z = zr[11:3]; e.pen = 1'b0;
    exp_q.push_back(e);
    m_pen = 1'b0;
    serve(2'b10, zr, 1'b1);
  endtask

  // ex/ey are the hand-computed scaled coordinates of the new reads.
  task automatic scan_down(input logic [11:0] zr, input logic [11:0] x0, input logic [11:0] dx,
                           input logic [11:0] y0, input logic [11:0] dy,
                           input logic [8:0] ex, input logic [8:0] ey);
    pub_t e;
    e.x = ex; e.y = ey; e.z = zr[11:3]; e.pen = 1'b1;
`ifdef TOUCH_SCHED_FILTER_EN
    if (m_pen) begin
      e.x = 9'((10'(m_x) + 10'(ex) + 10'd1) >> 1);
      e.y = 9'((10'(m_y) + 10'(ey) + 10'd1) >> 1);
    end
`endif
    exp_q.push_back(e);
    m_x = e.x; m_y = e.y; m_pen = 1'b1;
    serve(2'b10, zr, 1'b1);
    for (int k = 0; k < 4; k++) serve(2'b00, 12'(x0 + 12'(k) * dx), 1'b1);
    for (int k = 0; k < 4; k++) serve(2'b01, 12'(y0 + 12'(k) * dy), 1'b1);
  endtask

  always @(negedge cclk) begin
    pub_t e;
    if (rstb && sample_valid) begin
      if (exp_q.size() == 0) begin
        CHECKS++;
        ERRORS++;
        $display("FAIL unexpected_strobe actual=strobe required=none x=%0h y=%0h z=%0h", x, y, z);
      end else begin
        e = exp_q.pop_front();
        chk("pub_x", 32'(x), 32'(e.x));
        chk("pub_y", 32'(y), 32'(e.y));
        chk("pub_z", 32'(z), 32'(e.z));
        chk("pub_pen", 32'(pen_down), 32'(e.pen));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int seen;
    cyc(3);
    chk("rst_req", 32'(xfer_req), 32'd0);
    chk("rst_chan", 32'(xfer_chan), 32'd3);
    chk("rst_xyz", 32'({x, y, z}), 32'd0);
    chk("rst_flags", 32'({pen_down, sample_valid, timeout_err}), 32'd0);
    rstb = 1'b1;
    enable = 1'b1;

    scan_up(12'h050);
    scan_down(12'h400, 12'h290, 12'h000, 12'h260, 12'h000, 9'h080, 9'h080);
    scan_down(12'h100, 12'h050, 12'h000, 12'h060, 12'h000, 9'h000, 9'h000);
    scan_up(12'h0FF);
    scan_down(12'hFFF, 12'hFFF, 12'h000, 12'h100, 12'h010, 9'h1FF, 9'h02E);
    scan_down(12'h800, 12'h200, 12'h001, 12'h460, 12'h000, 9'h05C, 9'h100);
    cyc(5);

    // Timeout: ack the Z request but never complete it.
    chk("terr_clear", 32'(timeout_err), 32'd0);
    serve(2'b10, 12'h000, 1'b0);
    cyc(3990);
    chk("terr_early", 32'(timeout_err), 32'd0);
    w = 0;
    while (!timeout_err && w < 300) begin
      cyc(1);
      w++;
    end
    chk("terr_set", 32'(timeout_err), 32'd1);
    scan_up(12'h080);
    cyc(5);
    chk("terr_sticky", 32'(timeout_err), 32'd1);

    // Enable drops while an X conversion is in flight.
    serve(2'b10, 12'h400, 1'b1);
    serve(2'b00, 12'h000, 1'b0);
    enable = 1'b0;
    cyc(2);
    xfer_data = 12'h290;
    xfer_done = 1'b1;
    cyc(1);
    xfer_done = 1'b0;
    xfer_data = '0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (xfer_req) seen++;
      cyc(1);
    end
    chk("req_after_disable", 32'(seen), 32'd0);
    enable = 1'b1;
    scan_up(12'h050);
    cyc(5);

    // Reset while a request is outstanding; a late done must be ignored.
    w = 0;
    while (!xfer_req && w < 1000) begin
      cyc(1);
      w++;
    end
    chk("req_before_reset", 32'(xfer_req), 32'd1);
    rstb = 1'b0;
    cyc(1);
    rstb = 1'b1;
    chk("rst2_req", 32'(xfer_req), 32'd0);
    chk("rst2_chan", 32'(xfer_chan), 32'd3);
    chk("rst2_xyz", 32'({x, y, z}), 32'd0);
    chk("rst2_flags", 32'({pen_down, timeout_err}), 32'd0);
    xfer_data = 12'h123;
    xfer_done = 1'b1;
    cyc(1);
    xfer_done = 1'b0;
    xfer_data = '0;
    m_x = '0; m_y = '0; m_pen = 1'b0;
    scan_up(12'h050);
    scan_down(12'h400, 12'h290, 12'h000, 12'h260, 12'h000, 9'h080, 9'h080);

    cyc(10);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", CHECKS, ERRORS);
    $finish;
  end

endmodule
